// File: rtl/cook_timer_ctrl.sv
// Microwave cook-time controller: keypad entry, BCD mm:ss countdown on the 1 Hz tick,
// door interlock / pause handling and a timed done indication.
module cook_timer_ctrl #(
    parameter int DONE_TICKS = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       start,
    input  logic       stop_clear,
    input  logic       door_closed,
    output logic       mag_on,
    output logic       done,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [1:0] state
);

    localparam int CNT_W = $clog2(DONE_TICKS + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COOK  = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [3:0]         r_mt, r_mo, r_st, r_so;
    logic [3:0]         w_mt_nxt, w_mo_nxt, w_st_nxt, w_so_nxt;
    logic [CNT_W-1:0]   r_done_cnt, w_done_cnt_nxt;
    logic               r_tick_prev;
    logic               w_tick_rise;
    logic               w_time_zero;
    logic               w_key_ok;

    logic [3:0]         w_mt_d, w_mo_d, w_st_d, w_so_d;
    logic               w_b0, w_b1, w_b2;
    logic               w_dec_zero;

    // One BCD digit step down; returns {borrow, new digit}, wrapping to `wrap` on borrow.
    function automatic logic [4:0] dec_digit(input logic [3:0] d, input logic [3:0] wrap);
        if (d == 4'd0)
            dec_digit = {1'b1, wrap};
        else
            dec_digit = {1'b0, d - 4'd1};
    endfunction

    assign w_tick_rise = tick & ~r_tick_prev;
    assign w_time_zero = ({r_mt, r_mo, r_st, r_so} == 16'd0);
    assign w_key_ok    = key_valid && (key_digit <= 4'd9);

    // Seconds tens only wraps to 5 when borrowed into, so entered 6..9 count down normally.
    assign {w_b0, w_so_d} = dec_digit(r_so, 4'd9);
    assign {w_b1, w_st_d} = w_b0 ? dec_digit(r_st, 4'd5) : {1'b0, r_st};
    assign {w_b2, w_mo_d} = w_b1 ? dec_digit(r_mo, 4'd9) : {1'b0, r_mo};
    assign w_mt_d         = w_b2 ? r_mt - 4'd1 : r_mt;
    assign w_dec_zero     = ({w_mt_d, w_mo_d, w_st_d, w_so_d} == 16'd0);

    always_comb begin
        w_state_nxt    = r_state;
        w_mt_nxt       = r_mt;
        w_mo_nxt       = r_mo;
        w_st_nxt       = r_st;
        w_so_nxt       = r_so;
        w_done_cnt_nxt = r_done_cnt;
        case (r_state)
            S_IDLE: begin
                if (stop_clear) begin
                    {w_mt_nxt, w_mo_nxt, w_st_nxt, w_so_nxt} = 16'd0;
                end else if (start && door_closed && !w_time_zero) begin
                    w_state_nxt = S_COOK;
                end else if (w_key_ok) begin
                    w_mt_nxt = r_mo;
                    w_mo_nxt = r_st;
                    w_st_nxt = r_so;
                    w_so_nxt = key_digit;
                end
            end
            S_COOK: begin
                if (stop_clear || !door_closed) begin
                    w_state_nxt = S_PAUSE;
                end else if (w_tick_rise) begin
                    w_mt_nxt = w_mt_d;
                    w_mo_nxt = w_mo_d;
                    w_st_nxt = w_st_d;
                    w_so_nxt = w_so_d;
                    if (w_dec_zero) begin
                        w_state_nxt    = S_DONE;
                        w_done_cnt_nxt = '0;
                    end
                end
            end
            S_PAUSE: begin
                if (stop_clear) begin
                    w_state_nxt = S_IDLE;
                    {w_mt_nxt, w_mo_nxt, w_st_nxt, w_so_nxt} = 16'd0;
                end else if (start && door_closed) begin
                    w_state_nxt = S_COOK;
                end
            end
            S_DONE: begin
                if (stop_clear) begin
                    w_state_nxt    = S_IDLE;
                    w_done_cnt_nxt = '0;
                end else if (w_tick_rise) begin
                    if (r_done_cnt == CNT_W'(DONE_TICKS - 1)) begin
                        w_state_nxt    = S_IDLE;
                        w_done_cnt_nxt = '0;
                    end else begin
                        w_done_cnt_nxt = r_done_cnt + 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_mt        <= 4'd0;
            r_mo        <= 4'd0;
            r_st        <= 4'd0;
            r_so        <= 4'd0;
            r_done_cnt  <= '0;
            r_tick_prev <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_mt        <= w_mt_nxt;
            r_mo        <= w_mo_nxt;
            r_st        <= w_st_nxt;
            r_so        <= w_so_nxt;
            r_done_cnt  <= w_done_cnt_nxt;
            r_tick_prev <= tick;
        end
    end

    assign mag_on   = (r_state == S_COOK);
    assign done     = (r_state == S_DONE);
    assign min_tens = r_mt;
    assign min_ones = r_mo;
    assign sec_tens = r_st;
    assign sec_ones = r_so;
    assign state    = r_state;

endmodule

// File: tb/tb_cook_timer_ctrl.sv
// Self-checking bench for cook_timer_ctrl: directed vector table, hand-written
// done/stop sequence, then randomized stimulus against a decimal-arithmetic model.
module tb_cook_timer_ctrl;

    localparam int DONE_TICKS = 3;

    logic       clk = 1'b0;
    logic       rst_n, tick, key_valid, start, stop_clear, door_closed;
    logic [3:0] key_digit;
    logic       mag_on, done;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic [1:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    cook_timer_ctrl #(.DONE_TICKS(DONE_TICKS)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .key_valid(key_valid),
        .key_digit(key_digit), .start(start), .stop_clear(stop_clear),
        .door_closed(door_closed), .mag_on(mag_on), .done(done),
        .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens),
        .sec_ones(sec_ones), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n, tick, kv;
        logic [3:0] kd;
        logic       start, sc, door;
        logic [1:0] exp_state;
        logic [15:0] exp_time;
    } vec_t;

    vec_t vecs[$];

    // Reference model: time held as a plain 4-digit decimal number mmss.
    int   m_state = 0;
    int   m_num   = 0;
    int   m_cnt   = 0;
    logic m_prev  = 1'b0;

    function automatic logic [15:0] to_bcd(input int n);
        to_bcd = {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    task automatic model_step();
        logic rise;
        int   mm, ss;
        if (!rst_n) begin
            m_state = 0; m_num = 0; m_cnt = 0; m_prev = 1'b0;
        end else begin
            rise = tick && !m_prev;
            mm = m_num / 100;
            ss = m_num % 100;
            case (m_state)
                0: if (stop_clear) m_num = 0;
                   else if (start && door_closed && m_num != 0) m_state = 1;
                   else if (key_valid && key_digit <= 9) m_num = (m_num * 10 + int'(key_digit)) % 10000;
                1: if (stop_clear || !door_closed) m_state = 2;
                   else if (rise) begin
                       m_num = (ss > 0) ? m_num - 1 : (mm - 1) * 100 + 59;
                       if (m_num == 0) begin m_state = 3; m_cnt = 0; end
                   end
                2: if (stop_clear) begin m_state = 0; m_num = 0; end
                   else if (start && door_closed) m_state = 1;
                default: if (stop_clear) begin m_state = 0; m_cnt = 0; end
                   else if (rise) begin
                       m_cnt++;
                       if (m_cnt == DONE_TICKS) begin m_state = 0; m_cnt = 0; end
                   end
            endcase
            m_prev = tick;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic t, input logic kv, input logic [3:0] kd,
                         input logic s, input logic c, input logic d);
        rst_n = r; tick = t; key_valid = kv; key_digit = kd;
        start = s; stop_clear = c; door_closed = d;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic expect_all(input string name, input logic [1:0] st, input logic [15:0] tm);
        chk({name, "_state"}, 32'(state), 32'(st));
        chk({name, "_time"},  32'({min_tens, min_ones, sec_tens, sec_ones}), 32'(tm));
        chk({name, "_mag"},   32'(mag_on), 32'(st == 2'd1));
        chk({name, "_done"},  32'(done), 32'(st == 2'd3));
    endtask

    task automatic add(input logic r, input logic t, input logic kv, input logic [3:0] kd,
                       input logic s, input logic c, input logic d,
                       input logic [1:0] st, input logic [15:0] tm);
        vec_t v;
        v.rst_n = r; v.tick = t; v.kv = kv; v.kd = kd;
        v.start = s; v.sc = c; v.door = d; v.exp_state = st; v.exp_time = tm;
        vecs.push_back(v);
    endtask

    initial begin
        rst_n = 1'b0; tick = 1'b0; key_valid = 1'b0; key_digit = 4'd0;
        start = 1'b0; stop_clear = 1'b0; door_closed = 1'b1;

        //  rst tk kv kd     st sc dr  state time
        add(0, 0, 0, 4'd0,  0, 0, 1,  0, 16'h0000);
        add(1, 0, 1, 4'd1,  0, 0, 1,  0, 16'h0001);
        add(1, 0, 1, 4'd3,  0, 0, 1,  0, 16'h0013);
        add(1, 0, 1, 4'd0,  0, 0, 1,  0, 16'h0130);
        add(1, 0, 1, 4'd12, 0, 0, 1,  0, 16'h0130);
        add(1, 0, 1, 4'd15, 0, 0, 1,  0, 16'h0130);
        add(1, 0, 0, 4'd0,  1, 0, 0,  0, 16'h0130);
        add(1, 0, 0, 4'd0,  0, 1, 1,  0, 16'h0000);
        add(1, 0, 0, 4'd0,  1, 0, 1,  0, 16'h0000);
        add(1, 0, 1, 4'd3,  0, 0, 1,  0, 16'h0003);
        add(1, 0, 0, 4'd0,  1, 0, 1,  1, 16'h0003);
        add(1, 1, 0, 4'd0,  0, 0, 1,  1, 16'h0002);
        add(1, 1, 0, 4'd0,  0, 0, 1,  1, 16'h0002);
        add(1, 0, 0, 4'd0,  0, 0, 1,  1, 16'h0002);
        add(1, 1, 0, 4'd0,  0, 0, 1,  1, 16'h0001);
        add(1, 0, 0, 4'd0,  0, 0, 1,  1, 16'h0001);
        add(1, 1, 0, 4'd0,  0, 0, 1,  3, 16'h0000);
        add(1, 1, 1, 4'd5,  1, 0, 1,  3, 16'h0000);
        add(1, 0, 0, 4'd0,  0, 0, 1,  3, 16'h0000);
        add(1, 1, 0, 4'd0,  0, 0, 1,  3, 16'h0000);
        add(1, 0, 0, 4'd0,  0, 0, 1,  3, 16'h0000);
        add(1, 1, 0, 4'd0,  0, 0, 1,  3, 16'h0000);
        add(1, 0, 0, 4'd0,  0, 0, 1,  3, 16'h0000);
        add(1, 1, 0, 4'd0,  0, 0, 1,  0, 16'h0000);
        add(1, 0, 1, 4'd1,  0, 0, 1,  0, 16'h0001);
        add(1, 0, 1, 4'd0,  0, 0, 1,  0, 16'h0010);
        add(1, 0, 1, 4'd0,  0, 0, 1,  0, 16'h0100);
        add(1, 0, 0, 4'd0,  1, 0, 1,  1, 16'h0100);
        add(1, 1, 0, 4'd0,  0, 0, 1,  1, 16'h0059);
        add(1, 0, 0, 4'd0,  0, 0, 1,  1, 16'h0059);
        add(1, 0, 0, 4'd0,  0, 1, 1,  2, 16'h0059);
        add(1, 1, 0, 4'd0,  0, 0, 1,  2, 16'h0059);
        add(1, 0, 0, 4'd0,  0, 0, 1,  2, 16'h0059);
        add(1, 0, 0, 4'd0,  1, 1, 1,  0, 16'h0000);
        add(1, 0, 1, 4'd1,  0, 0, 1,  0, 16'h0001);
        add(1, 0, 1, 4'd0,  0, 0, 1,  0, 16'h0010);
        add(1, 0, 1, 4'd0,  0, 0, 1,  0, 16'h0100);
        add(1, 0, 1, 4'd0,  0, 0, 1,  0, 16'h1000);
        add(1, 0, 0, 4'd0,  1, 0, 1,  1, 16'h1000);
        add(1, 1, 0, 4'd0,  0, 0, 1,  1, 16'h0959);
        add(1, 0, 0, 4'd0,  0, 0, 1,  1, 16'h0959);
        add(1, 0, 0, 4'd0,  0, 1, 1,  2, 16'h0959);
        add(1, 0, 0, 4'd0,  0, 1, 1,  0, 16'h0000);
        add(1, 0, 1, 4'd7,  0, 0, 1,  0, 16'h0007);
        add(1, 0, 1, 4'd5,  0, 0, 1,  0, 16'h0075);
        add(1, 0, 0, 4'd0,  1, 0, 1,  1, 16'h0075);
        add(1, 1, 0, 4'd0,  0, 0, 1,  1, 16'h0074);
        add(1, 0, 0, 4'd0,  0, 0, 1,  1, 16'h0074);
        add(1, 0, 0, 4'd0,  0, 0, 0,  2, 16'h0074);
        add(1, 0, 0, 4'd0,  1, 0, 0,  2, 16'h0074);
        add(1, 0, 0, 4'd0,  0, 1, 1,  0, 16'h0000);
        add(1, 0, 1, 4'd1,  0, 0, 1,  0, 16'h0001);
        add(1, 0, 1, 4'd0,  0, 0, 1,  0, 16'h0010);
        add(1, 0, 0, 4'd0,  1, 0, 1,  1, 16'h0010);
        add(1, 1, 0, 4'd0,  0, 0, 0,  2, 16'h0010);
        add(1, 0, 0, 4'd0,  0, 0, 1,  2, 16'h0010);
        add(1, 0, 0, 4'd0,  1, 0, 1,  1, 16'h0010);
        add(1, 1, 0, 4'd0,  0, 0, 1,  1, 16'h0009);
        add(1, 0, 0, 4'd0,  0, 0, 1,  1, 16'h0009);
        add(0, 0, 0, 4'd0,  0, 0, 1,  0, 16'h0000);
        add(1, 0, 1, 4'd9,  0, 0, 1,  0, 16'h0009);
        add(1, 0, 1, 4'd9,  0, 0, 1,  0, 16'h0099);
        add(1, 0, 1, 4'd9,  0, 0, 1,  0, 16'h0999);
        add(1, 0, 1, 4'd9,  0, 0, 1,  0, 16'h9999);
        add(1, 0, 0, 4'd0,  1, 0, 1,  1, 16'h9999);
        add(1, 1, 0, 4'd0,  0, 0, 1,  1, 16'h9998);
        add(1, 0, 0, 4'd0,  0, 0, 1,  1, 16'h9998);
        add(1, 0, 0, 4'd0,  0, 1, 1,  2, 16'h9998);
        add(1, 0, 0, 4'd0,  0, 1, 1,  0, 16'h0000);
        add(1, 0, 1, 4'd6,  0, 0, 1,  0, 16'h0006);
        add(1, 0, 1, 4'd0,  0, 0, 1,  0, 16'h0060);
        add(1, 0, 0, 4'd0,  1, 0, 1,  1, 16'h0060);
        add(1, 1, 0, 4'd0,  0, 0, 1,  1, 16'h0059);
        add(1, 0, 0, 4'd0,  0, 0, 1,  1, 16'h0059);
        add(1, 0, 0, 4'd0,  0, 1, 1,  2, 16'h0059);
        add(1, 0, 0, 4'd0,  0, 1, 1,  0, 16'h0000);

        @(negedge clk);
        foreach (vecs[i]) begin
            drive(vecs[i].rst_n, vecs[i].tick, vecs[i].kv, vecs[i].kd,
                  vecs[i].start, vecs[i].sc, vecs[i].door);
            expect_all($sformatf("row%0d", i), vecs[i].exp_state, vecs[i].exp_time);
        end

        // DONE cut short by stop_clear before the done-tick count expires.
        drive(1, 0, 1, 4'd2, 0, 0, 1); expect_all("seq_key2", 2'd0, 16'h0002);
        drive(1, 0, 0, 4'd0, 1, 0, 1); expect_all("seq_start", 2'd1, 16'h0002);
        drive(1, 1, 0, 4'd0, 0, 0, 1); expect_all("seq_t1", 2'd1, 16'h0001);
        drive(1, 0, 0, 4'd0, 0, 0, 1); expect_all("seq_t1lo", 2'd1, 16'h0001);
        drive(1, 1, 0, 4'd0, 0, 0, 1); expect_all("seq_done", 2'd3, 16'h0000);
        drive(1, 0, 0, 4'd0, 0, 0, 1); expect_all("seq_donelo", 2'd3, 16'h0000);
        drive(1, 1, 0, 4'd0, 0, 0, 1); expect_all("seq_done_t1", 2'd3, 16'h0000);
        drive(1, 0, 0, 4'd0, 0, 1, 1); expect_all("seq_stop", 2'd0, 16'h0000);
        drive(1, 1, 0, 4'd0, 0, 0, 1); expect_all("seq_idle_tick", 2'd0, 16'h0000);
        drive(1, 0, 1, 4'd4, 0, 0, 1); expect_all("seq_key4", 2'd0, 16'h0004);

        // Randomized phase against the model.
        drive(0, 0, 0, 4'd0, 0, 0, 1);
        for (int n = 0; n < 4000; n++) begin
            int   a;
            logic t_next;
            a = $urandom_range(0, 99);
            t_next = ($urandom_range(0, 3) == 0) ? ~tick : tick;
            drive(($urandom_range(0, 999) != 0), t_next, (a < 30), 4'($urandom_range(0, 15)),
                  (a >= 30 && a < 45), (a >= 45 && a < 48), ($urandom_range(0, 29) != 0));
            chk($sformatf("rnd%0d", n),
                32'({state, min_tens, min_ones, sec_tens, sec_ones, mag_on, done}),
                32'({2'(m_state), to_bcd(m_num), (m_state == 1), (m_state == 3)}));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
